// File: rtl/priority_req_sched.sv
// Sticky request capture with lowest-index-first grant sequencing.
// Presents one grant at a time on a valid/ready port; no pulse is lost.
module priority_req_sched #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N-1:0]     i_req_in,
   input  logic             i_enable,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [IDX_W-1:0] o_out_idx,
   output logic [N-1:0]     o_pending,
   output logic             o_merge,
   output logic [7:0]       o_merge_cnt
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           r_state;
   logic [N-1:0]     r_pending;
   logic [IDX_W-1:0] r_idx;
   logic             r_merge;
   logic [7:0]       r_merge_cnt;

   logic             w_any;
   logic             w_load;
   logic [IDX_W-1:0] w_sel;
   logic [N-1:0]     w_clr;
   logic             w_hit;

   assign w_any  = |r_pending;
   assign w_load = i_enable && w_any &&
                   ((r_state == IDLE) || i_out_ready);
   assign w_hit  = |(i_req_in & r_pending & ~w_clr);

   // Lowest set pending bit wins; scanning downward lets it overwrite.
   always_comb begin
      w_sel = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (r_pending[i]) w_sel = IDX_W'(i);
      end
   end

   // One-hot mask of the bit retired by this cycle's load.
   always_comb begin
      w_clr = '0;
      for (int i = 0; i < N; i++) begin
         w_clr[i] = w_load && (w_sel == IDX_W'(i));
      end
   end

   // Pending capture, merge tracking and the grant state machine.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_pending   <= '0;
         r_idx       <= '0;
         r_merge     <= 1'b0;
         r_merge_cnt <= 8'd0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | i_req_in;
         r_merge   <= w_hit;
         if (w_hit && (r_merge_cnt != 8'hFF)) begin
            r_merge_cnt <= r_merge_cnt + 8'd1;
         end
         unique case (r_state)
            IDLE: begin
               if (w_load) begin
                  r_idx   <= w_sel;
                  r_state <= HOLD;
               end
            end
            HOLD: begin
               if (w_load) begin
                  r_idx <= w_sel;
               end else if (i_out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_out_valid = (r_state == HOLD);
   assign o_out_idx   = r_idx;
   assign o_pending   = r_pending;
   assign o_merge     = r_merge;
   assign o_merge_cnt = r_merge_cnt;

endmodule

// File: tb/tb_priority_req_sched.sv
// Bench for priority_req_sched: vector table, directed corner cases,
// and random traffic against a bitmask-arithmetic reference model.
module tb_priority_req_sched;

   localparam int N     = 4;
   localparam int IDX_W = 2;

   logic             clk;
   logic             rst;
   logic [N-1:0]     req_in;
   logic             enable;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic [N-1:0]     pending;
   logic             merge;
   logic [7:0]       merge_cnt;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_pend, m_valid, m_idx, m_merge, m_cnt;

   priority_req_sched #(.N(N), .IDX_W(IDX_W)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_in    (req_in),
      .i_enable    (enable),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_idx   (out_idx),
      .o_pending   (pending),
      .o_merge     (merge),
      .o_merge_cnt (merge_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic [3:0] q;
      logic       e;
      logic       y;
      logic       v;
      logic [1:0] idx;
      logic [3:0] pend;
      logic       mg;
      logic [7:0] cnt;
   } vec_t;

   vec_t vt[27];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: grant the lowest pending bit, isolated by p & -p.
   task automatic model(input logic r, input int q, input logic e,
                        input logic y);
      int low, clr, ld;
      if (r) begin
         m_pend = 0; m_valid = 0; m_idx = 0; m_merge = 0; m_cnt = 0;
         return;
      end
      ld  = (e && m_pend != 0 && (!m_valid || y)) ? 1 : 0;
      low = m_pend & -m_pend;
      clr = ld ? low : 0;
      m_merge = ((q & m_pend & ~clr) != 0) ? 1 : 0;
      if (m_merge && m_cnt < 255) m_cnt++;
      m_pend = ((m_pend & ~clr) | q) & 15;
      if (ld) begin
         m_valid = 1;
         m_idx   = $clog2(low);
      end else if (m_valid && y) begin
         m_valid = 0;
      end
   endtask

   task automatic step(input logic r, input logic [3:0] q, input logic e,
                       input logic y);
      @(negedge clk);
      rst = r; req_in = q; enable = e; out_ready = y;
      @(posedge clk);
      model(r, int'(q), e, y);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".valid"}, int'(out_valid), m_valid);
      if (m_valid) chk({tag, ".idx"}, int'(out_idx), m_idx);
      chk({tag, ".pend"}, int'(pending), m_pend);
      chk({tag, ".merge"}, int'(merge), m_merge);
      chk({tag, ".cnt"}, int'(merge_cnt), m_cnt);
   endtask

   function automatic vec_t mk(logic r, logic [3:0] q, logic e, logic y,
                               logic v, logic [1:0] i, logic [3:0] p,
                               logic mg, logic [7:0] c);
      vec_t t;
      t.r = r; t.q = q; t.e = e; t.y = y; t.v = v;
      t.idx = i; t.pend = p; t.mg = mg; t.cnt = c;
      return t;
   endfunction

   initial begin
      logic [3:0] rq;
      rst = 1'b1; req_in = '0; enable = 1'b0; out_ready = 1'b0;
      m_pend = 0; m_valid = 0; m_idx = 0; m_merge = 0; m_cnt = 0;

      // reset, single request
      vt[0]  = mk(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);
      vt[1]  = mk(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);
      vt[2]  = mk(0, 4'b0100, 1, 0, 0, 0, 4'b0100, 0, 0);
      vt[3]  = mk(0, 4'b0000, 1, 0, 1, 2, 4'b0000, 0, 0);
      vt[4]  = mk(0, 4'b0000, 1, 1, 0, 2, 4'b0000, 0, 0);
      // back-to-back grants 0,1,3
      vt[5]  = mk(0, 4'b1011, 1, 1, 0, 2, 4'b1011, 0, 0);
      vt[6]  = mk(0, 4'b0000, 1, 1, 1, 0, 4'b1010, 0, 0);
      vt[7]  = mk(0, 4'b0000, 1, 1, 1, 1, 4'b1000, 0, 0);
      vt[8]  = mk(0, 4'b0000, 1, 1, 1, 3, 4'b0000, 0, 0);
      vt[9]  = mk(0, 4'b0000, 1, 1, 0, 3, 4'b0000, 0, 0);
      // stall with 0110
      vt[10] = mk(0, 4'b0110, 1, 0, 0, 3, 4'b0110, 0, 0);
      vt[11] = mk(0, 4'b0000, 1, 0, 1, 1, 4'b0100, 0, 0);
      vt[12] = mk(0, 4'b0000, 1, 0, 1, 1, 4'b0100, 0, 0);
      vt[13] = mk(0, 4'b0000, 1, 0, 1, 1, 4'b0100, 0, 0);
      vt[14] = mk(0, 4'b0000, 1, 0, 1, 1, 4'b0100, 0, 0);
      vt[15] = mk(0, 4'b0000, 1, 0, 1, 1, 4'b0100, 0, 0);
      vt[16] = mk(0, 4'b0000, 1, 1, 1, 2, 4'b0000, 0, 0);
      vt[17] = mk(0, 4'b0000, 1, 1, 0, 2, 4'b0000, 0, 0);
      // re-request on the bit being cleared
      vt[18] = mk(0, 4'b0001, 1, 1, 0, 2, 4'b0001, 0, 0);
      vt[19] = mk(0, 4'b0001, 1, 1, 1, 0, 4'b0001, 0, 0);
      vt[20] = mk(0, 4'b0000, 1, 1, 1, 0, 4'b0000, 0, 0);
      vt[21] = mk(0, 4'b0000, 1, 1, 0, 0, 4'b0000, 0, 0);
      // merge, then grant accepted while disabled
      vt[22] = mk(0, 4'b0010, 0, 0, 0, 0, 4'b0010, 0, 0);
      vt[23] = mk(0, 4'b0010, 0, 0, 0, 0, 4'b0010, 1, 1);
      vt[24] = mk(0, 4'b0000, 1, 0, 1, 1, 4'b0000, 0, 1);
      vt[25] = mk(0, 4'b0000, 0, 0, 1, 1, 4'b0000, 0, 1);
      vt[26] = mk(0, 4'b0000, 0, 1, 0, 1, 4'b0000, 0, 1);

      for (int i = 0; i < 27; i++) begin
         step(vt[i].r, vt[i].q, vt[i].e, vt[i].y);
         chk($sformatf("vec%0d.valid", i), int'(out_valid), int'(vt[i].v));
         chk($sformatf("vec%0d.idx", i), int'(out_idx), int'(vt[i].idx));
         chk($sformatf("vec%0d.pend", i), int'(pending), int'(vt[i].pend));
         chk($sformatf("vec%0d.merge", i), int'(merge), int'(vt[i].mg));
         chk($sformatf("vec%0d.cnt", i), int'(merge_cnt), int'(vt[i].cnt));
      end

      // merge saturation with enable low
      step(1, 4'b0000, 0, 0);
      for (int k = 0; k < 300; k++) begin
         step(0, 4'b1000, 0, 1);
         chk("sat.merge", int'(merge), (k > 0) ? 1 : 0);
         chk("sat.cnt", int'(merge_cnt), (k > 255) ? 255 : k);
         chk("sat.valid", int'(out_valid), 0);
      end
      chk("sat.final", int'(merge_cnt), 255);

      // reset while holding a grant with 1100 still pending
      step(1, 4'b0000, 0, 0);
      step(0, 4'b1110, 0, 0);
      step(0, 4'b1000, 0, 0);
      chk("mid.cnt_pre", int'(merge_cnt), 1);
      step(0, 4'b0000, 1, 0);
      chk("mid.valid_pre", int'(out_valid), 1);
      chk("mid.idx_pre", int'(out_idx), 1);
      chk("mid.pend_pre", int'(pending), 4'b1100);
      step(1, 4'b0000, 1, 0);
      chk("mid.valid", int'(out_valid), 0);
      chk("mid.pend", int'(pending), 0);
      chk("mid.cnt", int'(merge_cnt), 0);
      chk("mid.merge", int'(merge), 0);

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rq = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) rq = 4'b0000;
         step(($urandom_range(0, 99) == 0), rq,
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
         chk_model("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
